// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ==== fetch_sequencer_if : instruction-memory, redirect, decode and fault signals (rev 1.0) ====

interface fetch_sequencer_if;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fault;
   logic [31:0] fault_pc;

   modport master (
      output mem_en, mem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
      input  mem_rdata, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  mem_en, mem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
      output mem_rdata, redirect_valid, redirect_pc, out_ready
   );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ==== fetch_sequencer : in-order fetch with one-entry skid, redirect and fault trap (rev 1.0) ====

module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 256
) (
   input  wire logic         clk,
   input  wire logic         rst,
   fetch_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [31:0] DEPTH_WORDS = 32'(DEPTH);

   state_t      state;
   logic [31:0] pc;
   logic        inflight;
   logic [31:0] inflight_pc;
   logic        skid_valid;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fault;
   logic [31:0] fault_pc;

   logic pc_bad;
   logic stall;
   logic issue;
   logic out_free;

   assign pc_bad   = (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= DEPTH_WORDS);
   assign stall    = out_valid && !bus.out_ready;
   // Issuing only with an empty skid and no stall guarantees the returning word always has a home.
   assign issue    = (state == RUN) && !pc_bad && !skid_valid && !stall;
   assign out_free = !out_valid || bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 32'd0;
         skid_valid  <= 1'b0;
         skid_instr  <= 32'd0;
         skid_pc     <= 32'd0;
         out_valid   <= 1'b0;
         out_instr   <= 32'd0;
         out_pc      <= 32'd0;
         fault       <= 1'b0;
         fault_pc    <= 32'd0;
      end else begin
         inflight    <= issue;
         inflight_pc <= pc;
         if (issue) begin
            pc <= pc + 32'd4;
         end

         if (out_free) begin
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_instr  <= skid_instr;
               out_pc     <= skid_pc;
               skid_valid <= inflight;
               if (inflight) begin
                  skid_instr <= bus.mem_rdata;
                  skid_pc    <= inflight_pc;
               end
            end else if (inflight) begin
               out_valid <= 1'b1;
               out_instr <= bus.mem_rdata;
               out_pc    <= inflight_pc;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (inflight) begin
            skid_valid <= 1'b1;
            skid_instr <= bus.mem_rdata;
            skid_pc    <= inflight_pc;
         end

         case (state)
            IDLE:    state <= RUN;
            RUN: begin
               if (pc_bad) begin
                  state    <= FAULT;
                  fault    <= 1'b1;
                  fault_pc <= pc;
               end
            end
            FAULT:   state <= FAULT;
            default: state <= IDLE;
         endcase

         // Redirect overrides everything above, including a fault detected this cycle.
         if (bus.redirect_valid) begin
            state      <= RUN;
            pc         <= bus.redirect_pc;
            inflight   <= 1'b0;
            skid_valid <= 1'b0;
            out_valid  <= 1'b0;
            fault      <= 1'b0;
         end
      end
   end

   assign bus.mem_en    = issue;
   assign bus.mem_addr  = pc;
   assign bus.out_valid = out_valid;
   assign bus.out_instr = out_instr;
   assign bus.out_pc    = out_pc;
   assign bus.fault     = fault;
   assign bus.fault_pc  = fault_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ==== tb_fetch_sequencer : directed scoreboard bench for fetch_sequencer (rev 1.0) ====

module tb_fetch_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   fetch_sequencer_if bus ();

   fetch_sequencer #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (256)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   function automatic logic [31:0] memval(input logic [31:0] a);
      return {8'hA5, 2'b00, a[23:2]};
   endfunction

   // Synchronous-read instruction memory: word appears one cycle after the strobe.
   always @(posedge clk) begin
      if (bus.mem_en) bus.mem_rdata <= memval(bus.mem_addr);
   end

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_out observed pc=%h instr=%h expected=none", bus.out_pc, bus.out_instr);
         end
         if (exp_q.size() != 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            n_assert++;
            assert ({bus.out_pc, bus.out_instr} === e) else begin
               n_fail++;
               $error("FAIL out_xfer observed pc=%h instr=%h expected pc=%h instr=%h",
                      bus.out_pc, bus.out_instr, e[63:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc);
      exp_q.push_back({pc, memval(pc)});
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (exp_q.size() == 0) break;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      repeat (3) tick();
      check("rst_mem_en",    32'(bus.mem_en),    32'd0);
      check("rst_mem_addr",  bus.mem_addr,       32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_instr", bus.out_instr,      32'd0);
      check("rst_out_pc",    bus.out_pc,         32'd0);
      check("rst_fault",     32'(bus.fault),     32'd0);
      check("rst_fault_pc",  bus.fault_pc,       32'd0);

      // Streaming from reset with decode always ready.
      for (int a = 0; a < 16; a += 4) push(32'(a));
      rst = 1'b0;
      #1;
      check("idle_mem_en", 32'(bus.mem_en), 32'd0);
      tick();
      check("c1_mem_en",     32'(bus.mem_en),    32'd1);
      check("c1_mem_addr",   bus.mem_addr,       32'h0);
      check("c1_out_valid",  32'(bus.out_valid), 32'd0);
      tick();
      check("c2_mem_addr",   bus.mem_addr,       32'h4);
      check("c2_out_valid",  32'(bus.out_valid), 32'd0);
      tick();
      check("c3_mem_addr",   bus.mem_addr,       32'h8);
      check("c3_out_valid",  32'(bus.out_valid), 32'd1);
      check("c3_out_pc",     bus.out_pc,         32'h0);
      tick();
      check("c4_mem_addr",   bus.mem_addr,       32'hC);
      tick();
      tick();
      check("c6_backlog",    32'(exp_q.size()),  32'd1);
      check("c6_out_pc",     bus.out_pc,         32'hC);

      // Three-cycle decode stall while streaming.
      tick();
      bus.out_ready = 1'b0;
      #1;
      check("stall0_mem_en", 32'(bus.mem_en), 32'd0);
      check("stall0_out_pc", bus.out_pc,      32'h10);
      for (int a = 16; a <= 32; a += 4) push(32'(a));
      tick();
      tick();
      check("stall2_mem_en",    32'(bus.mem_en), 32'd0);
      check("stall2_out_pc",    bus.out_pc,      32'h10);
      check("stall2_out_instr", bus.out_instr,   memval(32'h10));
      tick();
      bus.out_ready = 1'b1;
      #1;
      check("release_skid_mem_en", 32'(bus.mem_en), 32'd0);
      wait_drain("stall_drain", 40);

      // Redirect while the next word is in flight.
      check("pre_redir_out_pc", bus.out_pc, 32'h24);
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      tick();
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      push(32'h40);
      push(32'h44);
      #1;
      check("redir_out_valid", 32'(bus.out_valid), 32'd0);
      check("redir_mem_en",    32'(bus.mem_en),    32'd1);
      check("redir_mem_addr",  bus.mem_addr,       32'h40);
      tick();
      check("redir2_out_valid", 32'(bus.out_valid), 32'd0);
      wait_drain("redir_drain", 20);

      // Fill the skid, then redirect to a misaligned target.
      bus.out_ready = 1'b0;
      #1;
      check("skid_fill_mem_en", 32'(bus.mem_en), 32'd0);
      check("skid_fill_out_pc", bus.out_pc,      32'h48);
      tick();
      check("skid_full_mem_en", 32'(bus.mem_en), 32'd0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h42;
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      check("mis_issue_mem_en",    32'(bus.mem_en),    32'd0);
      check("mis_issue_mem_addr",  bus.mem_addr,       32'h42);
      check("mis_issue_out_valid", 32'(bus.out_valid), 32'd0);
      check("mis_issue_fault",     32'(bus.fault),     32'd0);
      tick();
      check("fault_set",       32'(bus.fault),  32'd1);
      check("fault_pc_mis",    bus.fault_pc,    32'h42);
      check("fault_mem_en",    32'(bus.mem_en), 32'd0);
      tick();
      tick();
      check("fault_sticky",    32'(bus.fault),  32'd1);
      check("fault_mem_en2",   32'(bus.mem_en), 32'd0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h10;
      tick();
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      push(32'h10);
      push(32'h14);
      #1;
      check("recover_fault",    32'(bus.fault),  32'd0);
      check("recover_mem_en",   32'(bus.mem_en), 32'd1);
      check("recover_mem_addr", bus.mem_addr,    32'h10);
      wait_drain("recover_drain", 20);

      // Walk off the end of the memory.
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h3F0;
      tick();
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      for (int a = 32'h3F0; a <= 32'h3FC; a += 4) push(32'(a));
      #1;
      check("edge_mem_addr", bus.mem_addr,    32'h3F0);
      check("edge_mem_en",   32'(bus.mem_en), 32'd1);
      wait_drain("edge_drain", 20);
      check("oor_fault",     32'(bus.fault),     32'd1);
      check("oor_fault_pc",  bus.fault_pc,       32'h400);
      check("oor_mem_en",    32'(bus.mem_en),    32'd0);
      check("oor_out_valid", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset in the middle of a stream.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h20;
      tick();
      bus.redirect_valid = 1'b0;
      push(32'h20);
      push(32'h24);
      wait_drain("pre_rst_drain", 20);
      bus.out_ready = 1'b0;
      #1;
      check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst_mem_en",    32'(bus.mem_en),    32'd0);
      check("async_rst_mem_addr",  bus.mem_addr,       32'h0);
      check("async_rst_out_pc",    bus.out_pc,         32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      push(32'h0);
      push(32'h4);
      #1;
      check("restart_idle_mem_en", 32'(bus.mem_en), 32'd0);
      tick();
      check("restart_mem_en",   32'(bus.mem_en), 32'd1);
      check("restart_mem_addr", bus.mem_addr,    32'h0);
      wait_drain("restart_drain", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
